// File: rtl/cpu_io_responder.sv
// Host-side IO responder: launches a CPU run, buffers flagged output words in a FIFO and streams them out.
// Optional CAPTURE_EDGE_EN: capture only on the rising edge of outFlagIO instead of every flagged cycle.
module cpu_io_responder #(
  parameter int WIDTH   = 24,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     go,
  output logic                     startIO,
  input  logic                     outFlagIO,
  input  logic [WIDTH-1:0]         cpuData,
  output logic [WIDTH-1:0]         rdata,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [PW:0]   FULL_COUNT = (PW+1)'(DEPTH);
  localparam logic [CW-1:0] QUIET_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state, nextState;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PW-1:0]     wrPtr, rdPtr;
  logic [CW-1:0]     quietCnt;
  logic              start, capture, full, pop, push, timeoutHit;

  assign start      = (state == IDLE) && go;
  assign full       = (count == FULL_COUNT);
  assign rvalid     = (count != '0);
  assign rdata      = mem[rdPtr];
  assign pop        = rvalid && rready && (state != IDLE);
  assign push       = capture && (!full || pop);
  assign timeoutHit = (state == RUN) && !outFlagIO && (quietCnt == QUIET_LAST);

`ifdef CAPTURE_EDGE_EN
  logic prevFlag;

  always_ff @(posedge clock) begin
    if (reset || start) prevFlag <= 1'b0;
    else                prevFlag <= outFlagIO;
  end

  assign capture = (state == RUN) && outFlagIO && !prevFlag;
`else
  assign capture = (state == RUN) && outFlagIO;
`endif

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (go) nextState = RUN;
      RUN:     if (timeoutHit) nextState = DRAIN;
      DRAIN:   if (count == '0) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Status outputs are registered from nextState so they align with the state they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      startIO <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= nextState;
      startIO <= (nextState == RUN);
      busy    <= (nextState == RUN) || (nextState == DRAIN);
      done    <= (nextState == DONE);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || start)     quietCnt <= '0;
    else if (state == RUN)  quietCnt <= outFlagIO ? '0 : quietCnt + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (start) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wrPtr] <= cpuData;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (capture && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_io_responder.sv
// Directed bench for cpu_io_responder: scoreboard queue of expected FIFO words checked as the consumer pops.
module tb_cpu_io_responder;

  logic        clock = 1'b0;
  logic        reset, go, outFlagIO, rready;
  logic [23:0] cpuData;
  logic        startIO, rvalid, busy, done, overflow;
  logic [23:0] rdata;
  logic [3:0]  count;

  logic        go4, flag4, rready4;
  logic [23:0] data4;
  logic        startIO4, rvalid4, busy4, done4, overflow4;
  logic [23:0] rdata4;
  logic [3:0]  count4;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned doneCnt = 0;
  bit          monEn = 1'b0;
  logic [23:0] expQ [$];

  always #5 clock = ~clock;

  cpu_io_responder #(.WIDTH(24), .DEPTH(8), .TIMEOUT(1024)) u_dut (
    .clock(clock), .reset(reset), .go(go), .startIO(startIO), .outFlagIO(outFlagIO),
    .cpuData(cpuData), .rdata(rdata), .rvalid(rvalid), .rready(rready), .count(count),
    .busy(busy), .done(done), .overflow(overflow)
  );

  cpu_io_responder #(.WIDTH(24), .DEPTH(8), .TIMEOUT(4)) u_dut4 (
    .clock(clock), .reset(reset), .go(go4), .startIO(startIO4), .outFlagIO(flag4),
    .cpuData(data4), .rdata(rdata4), .rvalid(rvalid4), .rready(rready4), .count(count4),
    .busy(busy4), .done(done4), .overflow(overflow4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic flagPulse(input logic [23:0] d, input bit keep);
    outFlagIO = 1'b1;
    cpuData   = d;
    if (keep) expQ.push_back(d);
    tick();
    outFlagIO = 1'b0;
  endtask

  task automatic startRun();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check(tag, {31'd0, seen}, 32'd1);
    tick();
  endtask

  // Consumer side: a pop happens at the next rising edge whenever rvalid & rready outside IDLE.
  always @(negedge clock) begin
    if (monEn && rvalid && rready) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $error("FAIL popEmpty: observed=%0h expected=none", rdata);
      end else begin
        check("popData", {8'd0, rdata}, {8'd0, expQ.pop_front()});
      end
    end
  end

  always @(negedge clock) if (done) doneCnt++;

  initial begin
    int unsigned dSnap;
    int unsigned nHeld;
    reset = 1'b1; go = 1'b0; outFlagIO = 1'b0; rready = 1'b0; cpuData = '0;
    go4 = 1'b0; flag4 = 1'b0; rready4 = 1'b1; data4 = '0;
    repeat (2) tick();
    check("rstStartIO", {31'd0, startIO}, 32'd0);
    check("rstRvalid", {31'd0, rvalid}, 32'd0);
    check("rstCount", {28'd0, count}, 32'd0);
    check("rstBusy", {31'd0, busy}, 32'd0);
    check("rstDone", {31'd0, done}, 32'd0);
    check("rstOverflow", {31'd0, overflow}, 32'd0);
    check("rstRdata", {8'd0, rdata}, 32'd0);
    reset = 1'b0;
    tick();

    // Basic run
    monEn = 1'b1;
    startRun();
    check("runStartIO", {31'd0, startIO}, 32'd1);
    check("runBusy", {31'd0, busy}, 32'd1);
    rready = 1'b1;
    flagPulse(24'h000005, 1'b1);
    tick();
    flagPulse(24'h00000A, 1'b1);
    tick();
    flagPulse(24'hFFFFFF, 1'b1);
    repeat (1023) tick();
    check("quietLast", {31'd0, startIO}, 32'd1);
    tick();
    check("drainStartIO", {31'd0, startIO}, 32'd0);
    check("drainBusy", {31'd0, busy}, 32'd1);
    check("basicQEmpty", expQ.size(), 32'd0);
    tick();
    check("donePulse", {31'd0, done}, 32'd1);
    check("doneBusy", {31'd0, busy}, 32'd0);
    tick();
    check("doneOnce", {31'd0, done}, 32'd0);
    check("doneCount", doneCnt, 32'd1);

    // Overflow
    rready = 1'b0;
    startRun();
    for (int v = 1; v <= 10; v++) begin
      flagPulse(24'(v), v <= 8);
      tick();
    end
    check("ovfCount", {28'd0, count}, 32'd8);
    check("ovfFlag", {31'd0, overflow}, 32'd1);
    rready = 1'b1;
    repeat (10) tick();
    check("ovfDrained", {28'd0, count}, 32'd0);
    check("ovfQEmpty", expQ.size(), 32'd0);
    waitDone("ovfWaitDone");
    check("ovfSticky", {31'd0, overflow}, 32'd1);
    startRun();
    check("ovfCleared", {31'd0, overflow}, 32'd0);

    // Full FIFO with simultaneous push and pop
    rready = 1'b0;
    for (int v = 1; v <= 8; v++) begin
      flagPulse(24'(v), 1'b1);
      tick();
    end
    check("fullCount", {28'd0, count}, 32'd8);
    rready = 1'b1;
    flagPulse(24'h000042, 1'b1);
    rready = 1'b0;
    check("pushPopCount", {28'd0, count}, 32'd8);
    check("pushPopOvf", {31'd0, overflow}, 32'd0);
    rready = 1'b1;
    repeat (10) tick();
    check("pushPopDrained", {28'd0, count}, 32'd0);
    check("pushPopQEmpty", expQ.size(), 32'd0);
    waitDone("pushPopWaitDone");

    // Reset mid-run
    monEn = 1'b0;
    rready = 1'b0;
    dSnap = doneCnt;
    startRun();
    for (int v = 0; v < 3; v++) begin
      flagPulse(24'h000100 + 24'(v), 1'b0);
      tick();
    end
    check("midCount", {28'd0, count}, 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midStartIO", {31'd0, startIO}, 32'd0);
    check("midRvalid", {31'd0, rvalid}, 32'd0);
    check("midCountRst", {28'd0, count}, 32'd0);
    check("midOverflow", {31'd0, overflow}, 32'd0);
    check("midBusy", {31'd0, busy}, 32'd0);
    repeat (1100) tick();
    check("midNoDone", doneCnt, dSnap);
    monEn = 1'b1;

    // Held flag
    startRun();
    outFlagIO = 1'b1;
    cpuData = 24'h123456;
    repeat (4) tick();
    outFlagIO = 1'b0;
`ifdef CAPTURE_EDGE_EN
    nHeld = 1;
`else
    nHeld = 4;
`endif
    for (int unsigned i = 0; i < nHeld; i++) expQ.push_back(24'h123456);
    check("heldCount", {28'd0, count}, nHeld);
    rready = 1'b1;
    repeat (6) tick();
    check("heldQEmpty", expQ.size(), 32'd0);
    waitDone("heldWaitDone");

    // Timeout boundary with TIMEOUT=4
    go4 = 1'b1;
    tick();
    go4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      flag4 = 1'b1;
      data4 = 24'(k + 1);
      tick();
      flag4 = 1'b0;
      repeat (3) tick();
      check("spacing4", {31'd0, startIO4}, 32'd1);
    end
    flag4 = 1'b1;
    tick();
    flag4 = 1'b0;
    repeat (3) tick();
    check("spacing5Run", {31'd0, startIO4}, 32'd1);
    tick();
    check("spacing5Drain", {31'd0, startIO4}, 32'd0);
    check("spacing5Busy", {31'd0, busy4}, 32'd1);
    begin
      bit seen4 = 1'b0;
      for (int i = 0; i < 50 && !seen4; i++) begin
        tick();
        if (done4) seen4 = 1'b1;
      end
      check("t4Done", {31'd0, seen4}, 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
